// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode/forwarding inputs and EX-stage outputs of the ID/EX pipeline register
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
);
    logic              id_valid;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [CTRL_W-1:0] id_alu_ctrl;
    logic              id_alu_src;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_reg_write;
    logic              hold;
    logic              flush;
    logic [4:0]        mem_rd;
    logic              mem_reg_write;
    logic [XLEN-1:0]   mem_result;
    logic [4:0]        wb_rd;
    logic              wb_reg_write;
    logic [XLEN-1:0]   wb_result;
    logic [XLEN-1:0]   alu_in_1;
    logic [XLEN-1:0]   alu_in_2;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [XLEN-1:0]   ex_store_data;
    logic [4:0]        ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_valid;
    logic              load_use_stall;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
               id_alu_ctrl, id_alu_src, id_mem_read, id_mem_write, id_reg_write,
               hold, flush, mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
        input  alu_in_1, alu_in_2, alu_ctrl, ex_store_data, ex_rd, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_valid, load_use_stall
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
               id_alu_ctrl, id_alu_src, id_mem_read, id_mem_write, id_reg_write,
               hold, flush, mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
        output alu_in_1, alu_in_2, alu_ctrl, ex_store_data, ex_rd, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_valid, load_use_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use hazard detect
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [CTRL_W-1:0] alu_ctrl;
        logic              alu_src;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
    } ex_reg_t;

    ex_reg_t         ex_q;
    ex_reg_t         ex_d;
    logic            stall;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // A load still in EX cannot feed the instruction in decode; rs2 only matters
    // when it is a real register operand or store data.
    always_comb begin
        stall = 1'b0;
        if (ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && bus.id_valid) begin
            if (bus.id_rs1 == ex_q.rd)
                stall = 1'b1;
            else if ((bus.id_rs2 == ex_q.rd) && (!bus.id_alu_src || bus.id_mem_write))
                stall = 1'b1;
        end
    end

    always_comb begin
        ex_d = '0;
        if (!bus.flush && !stall && bus.id_valid) begin
            ex_d.valid     = 1'b1;
            ex_d.rs1       = bus.id_rs1;
            ex_d.rs2       = bus.id_rs2;
            ex_d.rd        = bus.id_rd;
            ex_d.rs1_data  = bus.id_rs1_data;
            ex_d.rs2_data  = bus.id_rs2_data;
            ex_d.imm       = bus.id_imm;
            ex_d.alu_ctrl  = bus.id_alu_ctrl;
            ex_d.alu_src   = bus.id_alu_src;
            ex_d.mem_read  = bus.id_mem_read;
            ex_d.mem_write = bus.id_mem_write;
            ex_d.reg_write = bus.id_reg_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ex_q <= '0;
        else if (!bus.hold)
            ex_q <= ex_d;
    end

    // Nearest producer wins; x0 is never forwarded.
    always_comb begin
        fwd_rs1 = ex_q.rs1_data;
        if (bus.mem_reg_write && (bus.mem_rd != 5'd0) && (bus.mem_rd == ex_q.rs1))
            fwd_rs1 = bus.mem_result;
        else if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == ex_q.rs1))
            fwd_rs1 = bus.wb_result;
    end

    always_comb begin
        fwd_rs2 = ex_q.rs2_data;
        if (bus.mem_reg_write && (bus.mem_rd != 5'd0) && (bus.mem_rd == ex_q.rs2))
            fwd_rs2 = bus.mem_result;
        else if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == ex_q.rs2))
            fwd_rs2 = bus.wb_result;
    end

    assign bus.alu_in_1       = fwd_rs1;
    assign bus.alu_in_2       = ex_q.alu_src ? ex_q.imm : fwd_rs2;
    assign bus.ex_store_data  = fwd_rs2;
    assign bus.alu_ctrl       = ex_q.alu_ctrl;
    assign bus.ex_rd          = ex_q.rd;
    assign bus.ex_reg_write   = ex_q.reg_write;
    assign bus.ex_mem_read    = ex_q.mem_read;
    assign bus.ex_mem_write   = ex_q.mem_write;
    assign bus.ex_valid       = ex_q.valid;
    assign bus.load_use_stall = stall;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized and directed bench for id_ex_stage against a behavioural model
module tb_id_ex_stage;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    id_ex_stage_if #(.XLEN(32), .CTRL_W(4)) bus ();

    id_ex_stage #(.XLEN(32), .CTRL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the instruction sitting in EX (all-zero = empty slot)
    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [3:0]  ctrl;
        logic        src, mr, mw, rw;
    } ex_t;

    ex_t m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] regval);
        if (bus.mem_reg_write && bus.mem_rd != 0 && bus.mem_rd == rs) return bus.mem_result;
        if (bus.wb_reg_write && bus.wb_rd != 0 && bus.wb_rd == rs) return bus.wb_result;
        return regval;
    endfunction

    function automatic logic model_stall();
        logic uses_rs2;
        uses_rs2 = !bus.id_alu_src || bus.id_mem_write;
        return m.valid && m.mr && m.rd != 0 && bus.id_valid &&
               (bus.id_rs1 == m.rd || (uses_rs2 && bus.id_rs2 == m.rd));
    endfunction

    function automatic ex_t model_next();
        ex_t n;
        if (bus.hold) return m;
        n = '0;
        if (bus.flush || model_stall() || !bus.id_valid) return n;
        n.valid = 1'b1;
        n.rs1 = bus.id_rs1;  n.rs2 = bus.id_rs2;  n.rd = bus.id_rd;
        n.d1 = bus.id_rs1_data;  n.d2 = bus.id_rs2_data;  n.imm = bus.id_imm;
        n.ctrl = bus.id_alu_ctrl;  n.src = bus.id_alu_src;
        n.mr = bus.id_mem_read;  n.mw = bus.id_mem_write;  n.rw = bus.id_reg_write;
        return n;
    endfunction

    task automatic check_outputs(input string tag);
        logic [31:0] r2;
        #1;
        r2 = fwd(m.rs2, m.d2);
        check({tag, "/alu_in_1"}, bus.alu_in_1, fwd(m.rs1, m.d1));
        check({tag, "/alu_in_2"}, bus.alu_in_2, m.src ? m.imm : r2);
        check({tag, "/store"},    bus.ex_store_data, r2);
        check({tag, "/alu_ctrl"}, bus.alu_ctrl, m.ctrl);
        check({tag, "/ex_rd"},    bus.ex_rd, m.rd);
        check({tag, "/reg_wr"},   bus.ex_reg_write, m.rw);
        check({tag, "/mem_rd"},   bus.ex_mem_read, m.mr);
        check({tag, "/mem_wr"},   bus.ex_mem_write, m.mw);
        check({tag, "/valid"},    bus.ex_valid, m.valid);
        check({tag, "/stall"},    bus.load_use_stall, model_stall());
    endtask

    // Check combinational outputs, then advance one edge; returns just after the next negedge.
    task automatic step(input string tag);
        ex_t nxt;
        check_outputs(tag);
        nxt = model_next();
        @(posedge clk);
        m = nxt;
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
        bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0; bus.id_alu_ctrl = 0;
        bus.id_alu_src = 0; bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_reg_write = 0;
        bus.hold = 0; bus.flush = 0;
        bus.mem_rd = 0; bus.mem_reg_write = 0; bus.mem_result = 0;
        bus.wb_rd = 0; bus.wb_reg_write = 0; bus.wb_result = 0;
    endtask

    task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                             input logic [3:0] ctrl, input logic src, input logic mr,
                             input logic mw, input logic rw);
        bus.id_valid = 1; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
        bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm; bus.id_alu_ctrl = ctrl;
        bus.id_alu_src = src; bus.id_mem_read = mr; bus.id_mem_write = mw; bus.id_reg_write = rw;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m       = '0;
        rst_n   = 1'b0;
        set_idle();
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // addi x5, x1, 3 with x1 = 7
        set_instr(5'd1, 5'd0, 5'd5, 32'd7, 32'd0, 32'd3, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1);
        step("addi");
        set_idle();
        #1;
        check("addi/a1", bus.alu_in_1, 32'd7);
        check("addi/a2", bus.alu_in_2, 32'd3);
        check("addi/ctrl", bus.alu_ctrl, 4'b0010);
        check("addi/rd", bus.ex_rd, 5'd5);
        check("addi/valid", bus.ex_valid, 1'b1);
        @(negedge clk);
        m = '0;

        // forwarding priority on rs1 = x3
        set_instr(5'd3, 5'd0, 5'd6, 32'h55, 32'd0, 32'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        step("fwd_load");
        set_idle();
        bus.hold = 1;
        bus.mem_rd = 3; bus.mem_reg_write = 1; bus.mem_result = 32'h10;
        bus.wb_rd = 3;  bus.wb_reg_write = 1;  bus.wb_result = 32'h20;
        #1 check("fwd/mem_wins", bus.alu_in_1, 32'h10);
        bus.mem_reg_write = 0;
        #1 check("fwd/wb", bus.alu_in_1, 32'h20);
        bus.mem_rd = 0; bus.wb_rd = 0; bus.mem_reg_write = 1;
        #1 check("fwd/x0_none", bus.alu_in_1, 32'h55);
        step("fwd_hold");
        set_idle();

        // load-use: lw x4 then add using x4 as rs2
        set_instr(5'd1, 5'd2, 5'd4, 32'd0, 32'd0, 32'd8, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1);
        step("lw1");
        set_instr(5'd2, 5'd4, 5'd7, 32'd1, 32'd2, 32'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 check("lu/add_stall", bus.load_use_stall, 1'b1);
        step("lu_add");
        #1 check("lu/bubble_valid", bus.ex_valid, 1'b0);
        check("lu/bubble_ctrl", bus.alu_ctrl, 4'b0000);
        set_instr(5'd1, 5'd2, 5'd4, 32'd0, 32'd0, 32'd8, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1);
        step("lw2");
        set_instr(5'd2, 5'd4, 5'd0, 32'd1, 32'd2, 32'd4, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        #1 check("lu/sw_stall", bus.load_use_stall, 1'b1);
        set_instr(5'd2, 5'd4, 5'd9, 32'd1, 32'd2, 32'd4, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 check("lu/addi_free", bus.load_use_stall, 1'b0);
        step("lu_addi");

        // flush and hold
        set_instr(5'd1, 5'd2, 5'd10, 32'd1, 32'd2, 32'd3, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.flush = 1;
        step("flush");
        #1 check("flush/valid", bus.ex_valid, 1'b0);
        bus.flush = 0;
        set_instr(5'd1, 5'd2, 5'd11, 32'd1, 32'd2, 32'd3, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b1);
        step("pre_hold");
        set_instr(5'd3, 5'd4, 5'd12, 32'd9, 32'd9, 32'd9, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.hold = 1; bus.flush = 1;
        step("hold_flush");
        #1 check("hold_flush/rd", bus.ex_rd, 5'd11);
        bus.flush = 0;
        step("hold2");
        bus.mem_rd = 1; bus.mem_reg_write = 1; bus.mem_result = 32'hABCD;
        #1 check("hold/fwd_live", bus.alu_in_1, 32'hABCD);
        check("hold/rd", bus.ex_rd, 5'd11);
        set_idle();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_instr($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom, $urandom, $urandom, $urandom_range(0, 15),
                      $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 1));
            bus.id_valid      = ($urandom_range(0, 7) != 0);
            bus.hold          = ($urandom_range(0, 7) == 0);
            bus.flush         = ($urandom_range(0, 7) == 0);
            bus.mem_rd        = $urandom_range(0, 7);
            bus.mem_reg_write = $urandom_range(0, 1);
            bus.mem_result    = $urandom;
            bus.wb_rd         = $urandom_range(0, 7);
            bus.wb_reg_write  = $urandom_range(0, 1);
            bus.wb_result     = $urandom;
            step("rand");
        end
        set_idle();

        // asynchronous reset mid-cycle with a valid instruction in EX
        set_instr(5'd1, 5'd2, 5'd13, 32'd5, 32'd6, 32'd7, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);
        step("pre_rst");
        set_idle();
        #2 rst_n = 1'b0;
        m = '0;
        check_outputs("in_rst");
        @(negedge clk);
        rst_n = 1'b1;
        set_instr(5'd1, 5'd2, 5'd14, 32'd5, 32'd6, 32'd7, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
        step("post_rst");
        #1 check("post_rst/valid", bus.ex_valid, 1'b1);
        check("post_rst/rd", bus.ex_rd, 5'd14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
